ls161_gen_counter: RTL
======================

Name: ls161_gen_counter

Overview:
- Parametrised successor to the team's 4-bit LS161-style synchronous counter.
- Generalised to WIDTH bits with a programmable terminal value (MOD_MAX) and up/down counting.
- Adds a synchronous clear, an explicit load/clear/count priority, an ENT-gated combinational RCO for cascading, and a registered one-cycle WRAP pulse.
- Used as a timebase/divider and as a cascadable stage in multi-digit counters.

Parameters:
- WIDTH, 4, counter width in bits (>=2).
- MOD_MAX, 2**WIDTH-1, terminal count when counting up; the up-wrap target when counting down (must be <= 2**WIDTH-1).
- RST_VAL, 0, value Q takes on asynchronous reset.

Ports:
- CLK  input  1  clock, rising edge.
- CLR_n  input  1  asynchronous active-low reset.
- SCLR_n  input  1  synchronous active-low clear (Q <= 0 at next edge).
- LOAD_n  input  1  synchronous active-low parallel load.
- D  input  WIDTH  parallel load data.
- ENP  input  1  count enable, parallel.
- ENT  input  1  count enable, trickle; also gates RCO.
- UP  input  1  direction: 1 = up, 0 = down.
- Q  output  WIDTH  counter value (registered).
- RCO  output  1  ripple carry out (combinational).
- WRAP  output  1  registered pulse, one cycle after a wrapping count.

Behaviour:
- Reset: while CLR_n=0, Q=RST_VAL, WRAP=0 and RCO is forced to 0. This is asynchronous; release takes effect at the next CLK edge.
- Priority at each rising CLK edge with CLR_n=1: SCLR_n=0 > LOAD_n=0 > count > hold.
  - SCLR_n=0: Q <= 0.
  - LOAD_n=0: Q <= D. D is loaded unmodified, even when D > MOD_MAX.
  - Count when ENP=1 and ENT=1:
    - Up: Q <= (Q >= MOD_MAX) ? 0 : Q+1.
    - Down: Q <= (Q == 0) ? MOD_MAX : Q-1.
  - Otherwise hold.
- Counting is modulo MOD_MAX+1; no arithmetic overflow beyond WIDTH bits.
- Counting up from a loaded value above MOD_MAX wraps to 0 on the next count.
- Counting down from a value above MOD_MAX decrements normally.
- RCO = CLR_n & ENT & ((UP & Q==MOD_MAX) | (~UP & Q==0)).
  - RCO ignores ENP, so cascaded stages can be chained through ENT.
  - RCO responds within the same cycle to changes on UP and ENT.
- WRAP: registered. Set to 1 for exactly one cycle after an edge on which a count occurred from the terminal value (up from Q>=MOD_MAX, or down from Q==0); 0 otherwise.
  - Load and clear never assert WRAP, even when they move Q across the terminal value.
- UP may change on any cycle; the direction sampled at the edge applies.
- Asserting CLR_n mid-count clears Q and WRAP immediately, regardless of CLK. No count occurs on the first edge after release unless enables are high at that edge.
- Latency: Q updates 1 cycle after the controlling inputs are sampled. RCO has 0 cycles of latency from Q/ENT/UP. WRAP appears 1 cycle after the wrapping edge, coincident with the wrapped Q.

Test Plan:
- WIDTH=4, MOD_MAX=15: release CLR_n with ENP=ENT=UP=1 for 17 edges -> Q goes 1..15, 0, 1. RCO=1 only while Q=15. WRAP=1 only in the cycle where Q=0.
- WIDTH=4, MOD_MAX=9, UP=0: load D=2, then count 4 edges -> Q=1, 0, 9, 8. RCO=1 while Q=0. WRAP pulses once, with Q=9.
- LOAD_n=0 and SCLR_n=0 on the same edge with D=7 -> Q=0. Next edge LOAD_n=0 only -> Q=7, WRAP stays 0.
- MOD_MAX=9, load D=12, UP=1, count 1 edge -> Q=0 and WRAP=1. With ENP=0 and ENT=1, Q holds at 0, and RCO=1 after setting UP=0.
- Cascade two instances (WIDTH=4, MOD_MAX=9), with the low stage's RCO driving the high stage's ENT, counting up from 0 -> after 100 edges high:low = 0:0. The high stage's WRAP pulses once, at the 100th edge.
- Assert CLR_n low mid-cycle at Q=5 -> Q=0 and WRAP=0 without a CLK edge. RCO=0 during reset even with UP=0 and ENT=1.

Source files
------------

// File: rtl/ls161_gen_counter.sv
// Parametrised LS161-style synchronous counter: modulo MOD_MAX+1, up/down,
// sync clear and load, ENT-gated combinational RCO and a registered WRAP pulse.
module ls161_gen_counter #(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] MOD_MAX = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             CLR_n,
  input  logic             SCLR_n,
  input  logic             LOAD_n,
  input  logic [WIDTH-1:0] D,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UP,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             WRAP
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             count_en;
  logic             at_top;
  logic             at_zero;

  assign count_en = ENP & ENT;
  assign at_top   = (q_q >= MOD_MAX);
  assign at_zero  = (q_q == '0);

  // Next value: clear beats load beats count beats hold
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (!SCLR_n) begin
      q_d = '0;
    end else if (!LOAD_n) begin
      q_d = D;
    end else if (count_en) begin
      if (UP) begin
        if (at_top) begin
          q_d    = '0;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          q_d    = MOD_MAX;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      q_q    <= RST_VAL;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  // Carry looks at exact equality with the terminal so cascaded stages chain via ENT
  assign RCO  = CLR_n & ENT & ((UP & (q_q == MOD_MAX)) | (~UP & at_zero));
  assign Q    = q_q;
  assign WRAP = wrap_q;

endmodule
